// File: rtl/model_reader_pkg.sv
// model_reader_pkg: shared sizes and types for the draw-command to model-buffer reader.
package model_reader_pkg;
  localparam int MAX_MODEL_COUNT = 10;
  localparam int MAX_TRIANGLE_COUNT = 512;
  localparam int MID_W = $clog2(MAX_MODEL_COUNT);
  localparam int IDX_W = $clog2(MAX_TRIANGLE_COUNT + 1);
  typedef enum logic {IDLE, STREAM} state_t;
  typedef struct packed {
    logic [31:0] v0;
    logic [31:0] v1;
    logic [31:0] v2;
  } triangle_t;
  typedef struct packed {
    logic last;
  } triangle_meta_t;
  typedef struct packed {
    logic [MID_W-1:0] model_index;
    logic [IDX_W-1:0] triangle_index;
  } modelbuf_read_t;
  typedef struct packed {
    logic [MID_W-1:0] model_id;
    logic [7:0]       instance_id;
  } draw_cmd_t;
  typedef struct packed {
    logic       last;
    logic [7:0] instance_id;
  } reader_meta_t;
endpackage

// File: rtl/model_reader.sv
// model_reader: issues triangle reads 0,1,2.. for each draw, forwards responses downstream
// and reports completion with the number of triangles emitted.
module model_reader
  import model_reader_pkg::*;
(
  input  logic           clk,
  input  logic           rstn,
  input  logic           draw_valid,
  output logic           draw_ready,
  input  draw_cmd_t      draw_data,
  output logic           buf_req_valid,
  input  logic           buf_req_ready,
  output modelbuf_read_t buf_req_data,
  input  logic           buf_rsp_valid,
  output logic           buf_rsp_ready,
  input  triangle_t      buf_rsp_data,
  input  triangle_meta_t buf_rsp_meta,
  output logic           out_valid,
  input  logic           out_ready,
  output triangle_t      out_data,
  output reader_meta_t   out_meta,
  output logic           done,
  output logic [IDX_W-1:0] done_count,
  output logic           done_empty
);
  localparam logic [IDX_W-1:0] TRI_MAX = IDX_W'(MAX_TRIANGLE_COUNT);
  state_t state, state_n;
  logic [MID_W-1:0] model_id;
  logic [7:0] instance_id;
  logic [IDX_W-1:0] idx, count, count_n;
  logic stop, pending;
  logic streaming, miss, last_rsp, fin, req_fire, out_fire;
  assign streaming = state == STREAM;
  // A request was accepted last cycle but nothing came back: index past the model's end.
  assign miss = pending && !buf_rsp_valid;
  assign last_rsp = buf_rsp_valid && buf_rsp_meta.last;
  assign req_fire = buf_req_valid && buf_req_ready;
  assign out_fire = out_valid && out_ready;
  assign count_n = out_fire && count != TRI_MAX ? count + IDX_W'(1) : count;
  assign fin = streaming && (miss || (last_rsp && out_ready) ||
               (idx == TRI_MAX && !pending && !buf_rsp_valid));
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE ? (draw_valid ? STREAM : IDLE) : (fin ? IDLE : STREAM);
  always_comb begin
    draw_ready = state == IDLE;
    buf_req_valid = streaming && !stop && !miss && !last_rsp && idx < TRI_MAX;
    buf_req_data = '{model_index: model_id, triangle_index: idx};
    buf_rsp_ready = streaming ? out_ready : 1'b1;
    out_valid = streaming && buf_rsp_valid;
    out_data = buf_rsp_data;
    out_meta = '{last: buf_rsp_meta.last, instance_id: instance_id};
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      model_id <= '0;
      instance_id <= '0;
      idx <= '0;
      count <= '0;
      stop <= 1'b0;
      pending <= 1'b0;
      done <= 1'b0;
      done_count <= '0;
      done_empty <= 1'b0;
    end else begin
      if (draw_valid && draw_ready) begin
        model_id <= draw_data.model_id;
        instance_id <= draw_data.instance_id;
        idx <= '0;
        count <= '0;
        stop <= 1'b0;
        pending <= 1'b0;
      end else if (streaming) begin
        idx <= req_fire ? idx + IDX_W'(1) : idx;
        pending <= req_fire;
        count <= count_n;
        stop <= stop || miss || last_rsp;
      end
      done <= fin;
      done_count <= fin ? count_n : done_count;
      done_empty <= fin && count_n == '0;
    end
endmodule

// File: tb/tb_model_reader.sv
// tb_model_reader: random-content model buffer plus directed draws, checked against
// expected streams derived from each model's size and contents.
module tb_model_reader;
  import model_reader_pkg::*;
  logic clk = 0, rstn = 0;
  always #5 clk = ~clk;
  logic draw_valid = 0, draw_ready;
  draw_cmd_t draw_data = '0;
  logic buf_req_valid, buf_req_ready;
  modelbuf_read_t buf_req_data;
  logic buf_rsp_valid, buf_rsp_ready;
  triangle_t buf_rsp_data;
  triangle_meta_t buf_rsp_meta;
  logic out_valid, out_ready = 1;
  triangle_t out_data;
  reader_meta_t out_meta;
  logic done, done_empty;
  logic [IDX_W-1:0] done_count;

  model_reader dut (
    .clk(clk), .rstn(rstn),
    .draw_valid(draw_valid), .draw_ready(draw_ready), .draw_data(draw_data),
    .buf_req_valid(buf_req_valid), .buf_req_ready(buf_req_ready), .buf_req_data(buf_req_data),
    .buf_rsp_valid(buf_rsp_valid), .buf_rsp_ready(buf_rsp_ready), .buf_rsp_data(buf_rsp_data),
    .buf_rsp_meta(buf_rsp_meta),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_meta(out_meta),
    .done(done), .done_count(done_count), .done_empty(done_empty)
  );

  int total = 0, bad = 0;
  int cyc = 0, hi_req = 0;
  bit bp = 0;
  int size [MAX_MODEL_COUNT];
  triangle_t mem [MAX_MODEL_COUNT][MAX_TRIANGLE_COUNT];
  typedef struct {triangle_t d; logic last; logic [7:0] inst; int c;} out_t;
  typedef struct {int cnt; logic empty; int c;} done_t;
  out_t out_q[$];
  done_t done_q[$];
  modelbuf_read_t req_q[$];
  int req_c[$], acc_c[$];
  out_t ot;
  done_t dt;

  function automatic bit hit(modelbuf_read_t r);
    return int'(r.model_index) < MAX_MODEL_COUNT && int'(r.triangle_index) < size[r.model_index];
  endfunction

  // Model buffer: registered response one cycle after an accepted in-range request;
  // out-of-range requests get no response; a stalled response blocks new requests.
  assign buf_req_ready = !buf_rsp_valid || buf_rsp_ready;
  always @(posedge clk or negedge rstn)
    if (!rstn) begin
      buf_rsp_valid <= 0;
      buf_rsp_data <= '0;
      buf_rsp_meta <= '0;
    end else if (buf_req_valid && buf_req_ready) begin
      buf_rsp_valid <= hit(buf_req_data);
      buf_rsp_data <= hit(buf_req_data) ? mem[buf_req_data.model_index][buf_req_data.triangle_index[8:0]] : '0;
      buf_rsp_meta.last <= hit(buf_req_data) && int'(buf_req_data.triangle_index) == size[buf_req_data.model_index] - 1;
    end else if (buf_rsp_ready) buf_rsp_valid <= 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rstn) begin
    if (draw_valid && draw_ready) acc_c.push_back(cyc);
    if (buf_req_valid && buf_req_ready) begin
      req_q.push_back(buf_req_data);
      req_c.push_back(cyc);
      if (int'(buf_req_data.triangle_index) >= MAX_TRIANGLE_COUNT) hi_req++;
    end
    if (out_valid && out_ready) begin
      ot.d = out_data; ot.last = out_meta.last; ot.inst = out_meta.instance_id; ot.c = cyc;
      out_q.push_back(ot);
    end
    if (done) begin
      dt.cnt = int'(done_count); dt.empty = done_empty; dt.c = cyc;
      done_q.push_back(dt);
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    out_q.delete(); done_q.delete(); req_q.delete(); req_c.delete(); acc_c.delete();
  endtask

  task automatic start(int m, logic [7:0] inst);
    int n0 = acc_c.size();
    int k = 0;
    draw_data = '{model_id: MID_W'(m), instance_id: inst};
    draw_valid = 1;
    while (acc_c.size() == n0 && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
    end
    draw_valid = 0;
    if (k == 3000) chk("accept_timeout", acc_c.size(), n0 + 1);
  endtask

  task automatic wait_done(int n);
    for (int k = 0; k < 3000 && done_q.size() < n; k++) @(posedge clk);
    #1;
    chk("done_seen", done_q.size(), n);
  endtask

  // Expected: requests 0..size-1 (a lone probe of 0 if empty), outputs in model order,
  // last only on the final triangle, done count = size.
  task automatic check_draw(int m, logic [7:0] inst, int ob, int rb, int k);
    int n = size[m];
    for (int i = 0; i < (n == 0 ? 1 : n); i++)
      if (rb + i < req_q.size()) begin
        chk("req_model", req_q[rb + i].model_index, m);
        chk("req_idx", req_q[rb + i].triangle_index, i);
      end else chk("req_missing", req_q.size(), rb + i + 1);
    for (int i = 0; i < n; i++)
      if (ob + i < out_q.size()) begin
        chk("out_data", out_q[ob + i].d, mem[m][i]);
        chk("out_last", out_q[ob + i].last, i == n - 1);
        chk("out_inst", out_q[ob + i].inst, inst);
      end else chk("out_missing", out_q.size(), ob + i + 1);
    if (k < done_q.size()) begin
      chk("done_count", done_q[k].cnt, n);
      chk("done_empty", done_q[k].empty, n == 0);
    end else chk("done_missing", done_q.size(), k + 1);
  endtask

  initial begin
    int t;
    logic [7:0] inst;
    size = '{2, 4, 3, 5, 0, 512, 10, 0, 0, 0};
    for (int m = 0; m < MAX_MODEL_COUNT; m++)
      for (int i = 0; i < MAX_TRIANGLE_COUNT; i++)
        mem[m][i] = {$urandom, $urandom, $urandom};
    #2;
    chk("rst_draw_ready", draw_ready, 1);
    chk("rst_req_valid", buf_req_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_done_count", done_count, 0);
    chk("rst_done_empty", done_empty, 0);
    @(posedge clk);
    #1;
    rstn = 1;
    repeat (2) @(posedge clk);
    #1;

    // three-triangle model, latency and throughput
    clear();
    start(2, 8'h5A);
    t = acc_c[0];
    wait_done(1);
    check_draw(2, 8'h5A, 0, 0, 0);
    chk("m2_req_total", req_q.size(), 3);
    chk("m2_out_total", out_q.size(), 3);
    chk("m2_first_req_cyc", req_c[0], t + 1);
    chk("m2_first_out_cyc", out_q[0].c, t + 2);
    chk("m2_last_out_cyc", out_q[2].c, t + 4);
    chk("m2_done_cyc", done_q[0].c, t + 5);
    chk("m2_ready_at_done", draw_ready, 1);

    // empty model: single probe, no output
    repeat (2) @(posedge clk);
    #1;
    clear();
    start(4, 8'h01);
    t = acc_c[0];
    wait_done(1);
    check_draw(4, 8'h01, 0, 0, 0);
    chk("m4_req_total", req_q.size(), 1);
    chk("m4_out_total", out_q.size(), 0);
    chk("m4_probe_cyc", req_c[0], t + 1);
    chk("m4_done_cyc", done_q[0].c, t + 3);

    // random backpressure
    repeat (2) @(posedge clk);
    #1;
    clear();
    bp = 1;
    inst = 8'($urandom_range(0, 255));
    start(3, inst);
    wait_done(1);
    bp = 0;
    check_draw(3, inst, 0, 0, 0);
    chk("m3_req_total", req_q.size(), 5);
    chk("m3_out_total", out_q.size(), 5);

    // back-to-back draws, second held pending during the first
    repeat (3) @(posedge clk);
    #1;
    clear();
    start(0, 8'h11);
    start(1, 8'h22);
    wait_done(2);
    check_draw(0, 8'h11, 0, 0, 0);
    check_draw(1, 8'h22, 2, 2, 1);
    chk("b2b_out_total", out_q.size(), 6);
    chk("b2b_req_total", req_q.size(), 6);
    chk("b2b_accept_at_done", acc_c[1], done_q[0].c);
    chk("b2b_last2", out_q[1].last, 1);
    chk("b2b_last6", out_q[5].last, 1);

    // full-capacity model
    repeat (2) @(posedge clk);
    #1;
    clear();
    hi_req = 0;
    inst = 8'($urandom_range(0, 255));
    start(5, inst);
    t = acc_c[0];
    wait_done(1);
    check_draw(5, inst, 0, 0, 0);
    chk("m5_out_total", out_q.size(), 512);
    chk("m5_req_total", req_q.size(), 512);
    chk("m5_no_idx_512", hi_req, 0);
    chk("m5_done_cyc", done_q[0].c, t + 514);

    // async reset mid-stream, then a clean restream of the same model
    repeat (2) @(posedge clk);
    #1;
    clear();
    start(6, 8'h77);
    for (int k = 0; k < 100 && out_q.size() < 3; k++) begin
      @(posedge clk);
      #1;
    end
    chk("rst_mid_outs", out_q.size(), 3);
    rstn = 0;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_req_valid", buf_req_valid, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_done_count", done_count, 0);
    chk("rst_mid_draw_ready", draw_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mid_no_done", done_q.size(), 0);
    chk("rst_rel_draw_ready", draw_ready, 1);
    clear();
    start(6, 8'h78);
    wait_done(1);
    check_draw(6, 8'h78, 0, 0, 0);
    chk("m6_out_total", out_q.size(), 10);
    chk("m6_req_total", req_q.size(), 10);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
